// File: rtl/step_reg_write_arbiter.sv
// Round-robin arbiter serialising register writes from NUM_REQ requesters onto one PWM register port, with motor-register flush on disable.
// Latency: grant in the request cycle (combinational req_ready), wr pulse one cycle later; grant-to-grant spacing MIN_GAP+2 cycles.
// Backpressure: requesters hold valid/addr/data until their one-hot req_ready; req_ready stays low while busy or a flush is pending.
module step_reg_write_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          MOTOR_NUM  = 8,
    parameter logic [15:0] FLUSH_BASE = 16'h0000,
    parameter int          MIN_GAP    = 2
) (
    input  logic                   hclk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_addr,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   nENIn,
    output logic [15:0]            address,
    output logic [15:0]            wrData,
    output logic                   wr,
    output logic                   busy
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        FLUSH_ISSUE,
        FLUSH_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [3:0]      r_gap_cnt;
    logic [15:0]     r_k;
    logic [GW-1:0]   r_last_grant;
    logic            r_nen_q;
    logic            r_flush_pending;
    logic [15:0]     r_address;
    logic [15:0]     r_wrdata;

    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [GW-1:0]   w_idx;
    logic            w_grant;
    logic            w_start_flush;
    logic            w_gap_done;
    logic            w_k_last;
    logic            w_nen_rise;

    assign w_gap_done = (r_gap_cnt == 4'(MIN_GAP - 1));
    assign w_k_last   = (r_k == 16'(MOTOR_NUM - 1));
    assign w_nen_rise = ~r_nen_q & nENIn;

    assign address = r_address;
    assign wrData  = r_wrdata;
    assign busy    = (r_state != IDLE) || r_flush_pending;

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = GW'((int'(r_last_grant) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobes; a pending flush takes priority over requests in IDLE.
    always_comb begin
        w_next_state  = r_state;
        req_ready     = '0;
        wr            = 1'b0;
        w_grant       = 1'b0;
        w_start_flush = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_flush_pending) begin
                    w_start_flush = 1'b1;
                    w_next_state  = FLUSH_ISSUE;
                end else if (w_found) begin
                    req_ready    = NUM_REQ'(1) << w_winner;
                    w_grant      = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                wr           = 1'b1;
                w_next_state = GAP;
            end
            GAP: begin
                if (w_gap_done) begin
                    w_next_state = IDLE;
                end
            end
            FLUSH_ISSUE: begin
                wr           = 1'b1;
                w_next_state = FLUSH_GAP;
            end
            FLUSH_GAP: begin
                if (w_gap_done) begin
                    w_next_state = w_k_last ? IDLE : FLUSH_ISSUE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: enable edge detect, flush bookkeeping, captured write, gap timing.
    always_ff @(posedge hclk) begin
        if (!rst) begin
            r_nen_q         <= 1'b1;
            r_flush_pending <= 1'b0;
            r_k             <= '0;
            r_gap_cnt       <= '0;
            r_last_grant    <= GW'(NUM_REQ - 1);
            r_address       <= '0;
            r_wrdata        <= '0;
        end else begin
            r_nen_q <= nENIn;

            // A new rising edge wins over the clear so a re-trigger is never lost.
            if (w_nen_rise) begin
                r_flush_pending <= 1'b1;
            end else if (w_start_flush) begin
                r_flush_pending <= 1'b0;
            end

            if (w_grant) begin
                r_address    <= req_addr[16*w_winner +: 16];
                r_wrdata     <= req_data[16*w_winner +: 16];
                r_last_grant <= w_winner;
            end

            if (w_start_flush) begin
                r_k       <= '0;
                r_address <= FLUSH_BASE;
                r_wrdata  <= '0;
            end

            if (r_state == FLUSH_GAP && w_gap_done && !w_k_last) begin
                r_k       <= r_k + 16'd1;
                r_address <= FLUSH_BASE + r_k + 16'd1;
            end

            if (r_state == GAP || r_state == FLUSH_GAP) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule
